// File: rtl/jump_pkg.sv
// Shared opcode map and next-PC helpers for the 16-bit core.
// Imported by jump and jump_ras; opcode values live only here.
package jump_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_BRANCH,
    SRC_CALL,
    SRC_RET
  } pc_src_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/jump_ras.sv
// Circular return-address stack; when full, a push silently replaces the oldest entry.
module jump_ras
  import jump_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] data_i,
  output logic [15:0] top_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, topIdx;
  logic [CW-1:0] count_q, count_d;

  // ptr_q is the next free slot, so the newest entry sits one below it.
  assign topIdx  = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
  assign top_o   = mem_q[topIdx];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
      if (!full_o) count_d = count_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d   = topIdx;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

endmodule

// File: rtl/jump.sv
// Next-PC selection: fall-through, conditional B, absolute CALL and RET.
// Define JUMP_RAS_EN to give RET an internal return-address stack.
module jump
  import jump_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] nxt_pc_o,
  input  logic [15:0] pc_i,
  input  logic [15:0] ex_instr_i,
  input  logic        branch_i,
  input  logic [15:0] if_pc_i,
  input  logic        hazard_i,
  input  logic [15:0] ret_addr_i,
  output logic        redirect_o
);

  logic [3:0]  opcode;
  logic [15:0] seqPc;
  logic [15:0] branchPc;
  logic [15:0] retTarget;
  pc_src_e     src;

  assign opcode   = ex_instr_i[15:12];
  assign seqPc    = if_pc_i + 16'd1;
  assign branchPc = pc_i + 16'd2 + sext8(ex_instr_i[7:0]);

`ifdef JUMP_RAS_EN
  logic        rasPush;
  logic        rasPop;
  logic        rasEmpty;
  logic        unusedRasFull;
  logic [15:0] rasTop;
  logic [15:0] linkPc;

  // A stalled instruction is replayed later, so it must not touch the stack now.
  assign rasPush = !hazard_i && (opcode == OP_CALL);
  assign rasPop  = !hazard_i && (opcode == OP_RET) && !rasEmpty;
  assign linkPc  = pc_i + 16'd1;

  jump_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rasPush),
    .pop_i   (rasPop),
    .data_i  (linkPc),
    .top_o   (rasTop),
    .empty_o (rasEmpty),
    .full_o  (unusedRasFull)
  );

  assign retTarget = rasEmpty ? ret_addr_i : rasTop;
`else
  logic unusedClkRst;

  assign unusedClkRst = clk_i ^ rst_i;
  assign retTarget    = ret_addr_i;
`endif

  always_comb begin
    src = SRC_SEQ;
    if (hazard_i) begin
      src = SRC_HOLD;
    end else begin
      case (opcode)
        OP_B:    src = branch_i ? SRC_BRANCH : SRC_SEQ;
        OP_CALL: src = SRC_CALL;
        OP_RET:  src = SRC_RET;
        default: src = SRC_SEQ;
      endcase
    end

    nxt_pc_o   = seqPc;
    redirect_o = 1'b0;
    case (src)
      SRC_HOLD:   nxt_pc_o = if_pc_i;
      SRC_BRANCH: begin
        nxt_pc_o   = branchPc;
        redirect_o = 1'b1;
      end
      SRC_CALL: begin
        nxt_pc_o   = {pc_i[15:12], ex_instr_i[11:0]};
        redirect_o = 1'b1;
      end
      SRC_RET: begin
        nxt_pc_o   = retTarget;
        redirect_o = 1'b1;
      end
      default: nxt_pc_o = seqPc;
    endcase
  end

endmodule

// File: tb/tb_jump.sv
// Self-checking bench for jump: per-cycle behavioural model plus literal spot checks.
// Exercises the stack scenarios only when JUMP_RAS_EN is defined.
module tb_jump;
  import jump_pkg::*;

  localparam int DEPTH = 8;
`ifdef JUMP_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nxtPc;
  logic [15:0] pc = 16'h0000;
  logic [15:0] exInstr = 16'h0000;
  logic        branch = 1'b0;
  logic [15:0] ifPc = 16'h0010;
  logic        hazard = 1'b0;
  logic [15:0] retAddr = 16'h0000;
  logic        redirect;

  int total = 0;
  int bad   = 0;
  logic [15:0] modelStack [$];

  jump #(.RAS_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .nxt_pc_o   (nxtPc),
    .pc_i       (pc),
    .ex_instr_i (exInstr),
    .branch_i   (branch),
    .if_pc_i    (ifPc),
    .hazard_i   (hazard),
    .ret_addr_i (retAddr),
    .redirect_o (redirect)
  );

  always #5 clk = ~clk;

  // Expected next PC written straight from the selection rules, signed offset as integer math.
  function automatic logic [16:0] modelNext();
    logic [3:0] op;
    int target;
    op = exInstr[15:12];
    if (hazard) return {1'b0, ifPc};
    if (op == OP_B && branch) begin
      target = int'(pc) + 2 + int'($signed(exInstr[7:0]));
      return {1'b1, 16'(target)};
    end
    if (op == OP_CALL) return {1'b1, pc[15:12], exInstr[11:0]};
    if (op == OP_RET) begin
      if (modelStack.size() > 0) return {1'b1, modelStack[$]};
      return {1'b1, retAddr};
    end
    return {1'b0, 16'(int'(ifPc) + 1)};
  endfunction

  always @(negedge clk) begin
    logic [16:0] exp;
    #2;
    exp = modelNext();
    total++;
    if ({redirect, nxtPc} !== exp) begin
      bad++;
      $display("[TB] FAIL model t=%0t op=%h got pc=%h redir=%b want pc=%h redir=%b",
               $time, exInstr[15:12], nxtPc, redirect, exp[15:0], exp[16]);
    end
    if (RAS) begin
      if (rst) begin
        modelStack.delete();
      end else if (!hazard && exInstr[15:12] == OP_CALL) begin
        if (modelStack.size() == DEPTH) void'(modelStack.pop_front());
        modelStack.push_back(16'(int'(pc) + 1));
      end else if (!hazard && exInstr[15:12] == OP_RET && modelStack.size() > 0) begin
        void'(modelStack.pop_back());
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [11:0] low,
                               input logic [15:0] pcV, input logic [15:0] ifV,
                               input logic br, input logic haz, input logic [15:0] ra);
    @(negedge clk);
    exInstr = {op, low};
    pc      = pcV;
    ifPc    = ifV;
    branch  = br;
    hazard  = haz;
    retAddr = ra;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expPc, input logic expRedir);
    #3;
    total++;
    if (nxtPc !== expPc || redirect !== expRedir) begin
      bad++;
      $display("[TB] FAIL %s got pc=%h redir=%b want pc=%h redir=%b",
               name, nxtPc, redirect, expPc, expRedir);
    end
  endtask

  initial begin
    logic [3:0] aluOps [13];
    logic [3:0] hazOps [4];
    aluOps = '{OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC, OP_SRA, OP_SRL, OP_SLL,
               OP_LW, OP_SW, OP_LHB, OP_LLB, 4'hF};
    hazOps = '{OP_ADD, OP_B, OP_CALL, OP_RET};

    applyStimulus(OP_ADD, 12'h000, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0000);
    applyStimulus(OP_ADD, 12'h000, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset", 16'h0011, 1'b0);
    applyStimulus(OP_ADD, 12'h000, 16'hB1AB, 16'hB1AB, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    checkOutput("add_br0", 16'hB1AC, 1'b0);
    applyStimulus(OP_ADD, 12'h000, 16'hB1AB, 16'hB1AB, 1'b1, 1'b0, 16'h0000);
    checkOutput("add_br1", 16'hB1AC, 1'b0);

    foreach (aluOps[i]) begin
      for (int b = 0; b < 2; b++) begin
        applyStimulus(aluOps[i], 12'h5A5, 16'hB0DE, 16'hB0DE, 1'(b), 1'b0, 16'h0000);
        checkOutput($sformatf("alu_op%h_br%0d", aluOps[i], b), 16'hB0DF, 1'b0);
      end
    end

    applyStimulus(OP_B, 12'h300, 16'h1055, 16'h1055, 1'b0, 1'b0, 16'h0000);
    checkOutput("b_not_taken", 16'h1056, 1'b0);
    applyStimulus(OP_B, 12'h300, 16'h1055, 16'h1055, 1'b1, 1'b0, 16'h0000);
    checkOutput("b_taken_off0", 16'h1057, 1'b1);
    applyStimulus(OP_B, 12'h0AB, 16'h0055, 16'h0100, 1'b1, 1'b0, 16'h0000);
    checkOutput("b_taken_neg", 16'h0002, 1'b1);
    applyStimulus(OP_B, 12'h07F, 16'hFFFF, 16'h0100, 1'b1, 1'b0, 16'h0000);
    checkOutput("b_wrap", 16'h0080, 1'b1);
    applyStimulus(OP_ADD, 12'h000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    checkOutput("seq_wrap", 16'h0000, 1'b0);

    applyStimulus(OP_RET, 12'h000, 16'h2000, 16'h2001, 1'b0, 1'b0, 16'h1234);
    checkOutput("ret_empty", 16'h1234, 1'b1);
    foreach (hazOps[i]) begin
      applyStimulus(hazOps[i], 12'h010, 16'h3000, 16'h4000, 1'b1, 1'b1, 16'h1234);
      checkOutput($sformatf("hazard_op%h", hazOps[i]), 16'h4000, 1'b0);
    end
    applyStimulus(OP_RET, 12'h000, 16'h2000, 16'h2001, 1'b0, 1'b0, 16'h5678);
    checkOutput("ret_after_hazard", 16'h5678, 1'b1);

    applyStimulus(OP_CALL, 12'h000, 16'hC0DA, 16'hC0DB, 1'b0, 1'b0, 16'h0000);
    checkOutput("call_br0", 16'hC000, 1'b1);
    applyStimulus(OP_CALL, 12'h000, 16'hC0DA, 16'hC0DB, 1'b1, 1'b0, 16'h0000);
    checkOutput("call_br1", 16'hC000, 1'b1);

`ifdef JUMP_RAS_EN
    applyStimulus(OP_RET, 12'h000, 16'hC000, 16'hC001, 1'b0, 1'b0, 16'h1111);
    checkOutput("ras_ret_call", 16'hC0DB, 1'b1);
    applyStimulus(OP_RET, 12'h000, 16'hC000, 16'hC001, 1'b0, 1'b0, 16'h1111);
    checkOutput("ras_ret_call2", 16'hC0DB, 1'b1);
    applyStimulus(OP_RET, 12'h000, 16'hC000, 16'hC001, 1'b0, 1'b0, 16'h1111);
    checkOutput("ras_ret_drained", 16'h1111, 1'b1);

    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(OP_CALL, 12'(i), 16'(16'h1000 + 16 * i), 16'h0800, 1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("ras_call%0d", i), 16'(16'h1000 + i), 1'b1);
    end
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(OP_RET, 12'h000, 16'h0900, 16'h0901, 1'b0, 1'b0, 16'h2222);
      checkOutput($sformatf("ras_ret%0d", k), 16'(16'h1000 + 16 * (DEPTH - k) + 1), 1'b1);
    end
    applyStimulus(OP_RET, 12'h000, 16'h0900, 16'h0901, 1'b0, 1'b0, 16'h2222);
    checkOutput("ras_underflow", 16'h2222, 1'b1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_CALL, 12'h100, 16'h7000, 16'h0800, 1'b0, 1'b0, 16'h0000);
    end
    applyStimulus(OP_ADD, 12'h000, 16'h0000, 16'h0500, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    checkOutput("ras_rst_cycle", 16'h0501, 1'b0);
    applyStimulus(OP_RET, 12'h000, 16'h0900, 16'h0901, 1'b0, 1'b0, 16'h3333);
    rst = 1'b0;
    checkOutput("ras_after_rst", 16'h3333, 1'b1);
`else
    applyStimulus(OP_RET, 12'h000, 16'hC000, 16'hC001, 1'b0, 1'b0, 16'h1111);
    checkOutput("ret_no_ras", 16'h1111, 1'b1);
`endif

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
